// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a DIGITS-wide seven-segment display with per-slot blanking.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [IDX_W-1:0]      scan_idx
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

`ifdef SEG7_LZB_EN
  // Bit i set when nibble i and every nibble above it are zero; digit 0 is always kept.
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] val);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (val[4*i +: 4] == 4'h0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction
`else
  function automatic logic [DIGITS-1:0] lzb_mask(input logic [4*DIGITS-1:0] val);
    return (val == val) ? '0 : '0;
  endfunction
`endif

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  state_t              state_q, state_d;
  logic [6:0]          seg_lit_q, seg_lit_d;
  logic                dp_lit_q, dp_lit_d;
  logic [DIGITS-1:0]   dig_lit_q, dig_lit_d;

  logic                tick;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lzb;
  logic [DIGITS-1:0]   cur_onehot;
  logic [DIGITS-1:0]   blank_mask;
  logic [6:0]          seg_act;

  always_comb begin
    cnt_d        = cnt_q;
    scan_idx_d   = scan_idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    state_d      = ST_BLANK;
    tick         = (cnt_q == CNT_LAST);
    blank_mask   = lzb_mask(shadow_val_q);
    cur_nib      = 4'h0;
    cur_dp       = 1'b0;
    cur_lzb      = 1'b0;
    cur_onehot   = '0;

    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_nib       = shadow_val_q[4*i +: 4];
        cur_dp        = shadow_dp_q[i];
        cur_lzb       = blank_mask[i];
        cur_onehot[i] = 1'b1;
      end
    end

    if (load) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
    end

    // The tick cycle of each slot is the blank cycle; the index advances behind it.
    if (en) begin
      if (tick) begin
        cnt_d      = '0;
        scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        state_d    = ST_BLANK;
      end else begin
        cnt_d      = cnt_q + 1'b1;
        state_d    = ST_SHOW;
      end
    end

    seg_act   = cur_lzb ? 7'h00 : hex_decode(cur_nib);
    seg_lit_d = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    dp_lit_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
    dig_lit_d = (DIG_ACTIVE_LOW != 0) ? ~cur_onehot : cur_onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      scan_idx_q   <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      state_q      <= ST_BLANK;
    end else begin
      cnt_q        <= cnt_d;
      scan_idx_q   <= scan_idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      state_q      <= state_d;
    end
  end

  // Lit patterns need no reset: the registered state forces the pins inactive.
  always_ff @(posedge clk) begin
    seg_lit_q <= seg_lit_d;
    dp_lit_q  <= dp_lit_d;
    dig_lit_q <= dig_lit_d;
  end

  assign seg_out  = (state_q == ST_SHOW) ? seg_lit_q : SEG_OFF;
  assign dp_out   = (state_q == ST_SHOW) ? dp_lit_q  : DP_OFF;
  assign dig_sel  = (state_q == ST_SHOW) ? dig_lit_q : DIG_OFF;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, active-low pins): directed table plus random run
// against a frame-position model; follows SEG7_LZB_EN if the build defines it.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic [1:0]  scan_idx;

  seg7_scan_driver #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value_in(value_in), .dp_in(dp_in),
    .seg_out(seg_out), .dp_out(dp_out), .dig_sel(dig_sel), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int passes = 0;
  int cyc_no = 0;

  // Model: shadow contents and the number of enabled edges since reset.
  int          en_cnt = 0;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_dp   = '0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic [1:0]  e_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_no, act, exp);
    else
      passes++;
  endtask

  task automatic cyc(input logic r, input logic e, input logic l,
                     input logic [15:0] v, input logic [3:0] d);
    int p, dig;
    logic [6:0] lit;
    rst_n = r; en = e; load = l; value_in = v; dp_in = d;
    @(posedge clk);
    cyc_no++;
    e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
    if (!r) begin
      en_cnt = 0; m_val = '0; m_dp = '0;
    end else begin
      if (e) begin
        p   = en_cnt % FRAME;
        dig = p / SCAN_DIV;
        if ((p % SCAN_DIV) != SCAN_DIV - 1) begin
          lit = seg_tab[(m_val >> (4 * dig)) & 16'hF];
          if (LZB && dig > 0 && (m_val >> (4 * dig)) == 0) lit = 7'h00;
          e_seg = ~lit;
          e_dp  = ~m_dp[dig];
          e_dig = ~(4'b0001 << dig);
        end
        en_cnt++;
      end
      if (l) begin
        m_val = v; m_dp = d;
      end
    end
    e_idx = 2'((en_cnt / SCAN_DIV) % DIGITS);
    #1;
    chk("model_seg", {25'b0, seg_out}, {25'b0, e_seg});
    chk("model_dp", {31'b0, dp_out}, {31'b0, e_dp});
    chk("model_dig", {28'b0, dig_sel}, {28'b0, e_dig});
    chk("model_idx", {30'b0, scan_idx}, {30'b0, e_idx});
  endtask

  typedef struct {
    logic        r, e, l;
    logic [15:0] v;
    logic [3:0]  d;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  dig;
    logic [1:0]  idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input logic l, input logic [15:0] v,
                              input logic [3:0] d, input logic [6:0] seg, input logic dpo,
                              input logic [3:0] dig, input logic [1:0] idx);
    vec_t t;
    t.r = r; t.e = e; t.l = l; t.v = v; t.d = d;
    t.seg = seg; t.dpo = dpo; t.dig = dig; t.idx = idx;
    return t;
  endfunction

  initial begin
    logic [6:0] zero_d1;
    logic [15:0] rv;
    zero_d1 = LZB ? 7'h7F : 7'h40;

    // Reset, then the 12AF scan frame.
    tbl.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 0));
    tbl.push_back(mk(0, 1, 1, 16'h1234, 4'hF, 7'h7F, 1, 4'hF, 0));
    tbl.push_back(mk(1, 1, 1, 16'h12AF, 4'h4, 7'h40, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h0E, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h0E, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 16'h0, 4'h0, 7'h08, 1, 4'hD, 1));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 16'h0, 4'h0, 7'h24, 0, 4'hB, 2));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, 0, 16'h0, 4'h0, 7'h79, 1, 4'h7, 3));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h0E, 1, 4'hE, 0));
    // Load mid-slot: new value appears one edge later, same digit.
    tbl.push_back(mk(1, 1, 1, 16'h0000, 4'h0, 7'h0E, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h40, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 1));
    // Enable gating mid-slot on digit 1.
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, zero_d1, 1, 4'hD, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 16'h0, 4'h0, 7'h7F, 1, 4'hF, 1));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, zero_d1, 1, 4'hD, 1));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, zero_d1, 1, 4'hD, 1));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 2));
    // Reset mid-scan on digit 2 clears the freshly loaded shadow.
    tbl.push_back(mk(1, 1, 1, 16'h5555, 4'hF, zero_d1, 1, 4'hB, 2));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h12, 0, 4'hB, 2));
    tbl.push_back(mk(0, 1, 0, 16'h0000, 4'h0, 7'h7F, 1, 4'hF, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h40, 1, 4'hE, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 4'h0, 7'h40, 1, 4'hE, 0));

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].e, tbl[k].l, tbl[k].v, tbl[k].d);
      chk("tbl_seg", {25'b0, seg_out}, {25'b0, tbl[k].seg});
      chk("tbl_dp", {31'b0, dp_out}, {31'b0, tbl[k].dpo});
      chk("tbl_dig", {28'b0, dig_sel}, {28'b0, tbl[k].dig});
      chk("tbl_idx", {30'b0, scan_idx}, {30'b0, tbl[k].idx});
    end

    // Randomized traffic, biased toward values with leading zeros.
    for (int n = 0; n < 3000; n++) begin
      rv = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rv = rv & 16'h00FF;
        1: rv = rv & 16'h000F;
        2: rv = 16'h0000;
        default: ;
      endcase
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 7) == 0, rv, 4'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
